ofm_checker: RTL and testbench

OFM_CHECKER -- requirements
Module: ofm_checker

---
 rtl/ofm_checker_if.sv | 19 +
 rtl/ofm_checker.sv | 141 ++++++++++++++
 tb/tb_ofm_checker.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ofm_checker_if.sv
// ofm_checker_if -- shared read bus between the OFM checker and the two
// memories it compares (RTL-produced OFM and golden reference).
//   rd_en        : read strobe, common to both memories
//   rd_addr      : linear channel-major word address, common to both memories
//   ofm_rd_data  : OFM word, returned one cycle after rd_en
//   gold_rd_data : golden word, returned one cycle after rd_en
// master = checker side, slave = memory side.
interface ofm_checker_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 14
);
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] ofm_rd_data;
    logic [DATA_WIDTH-1:0] gold_rd_data;

    modport master (output rd_en, rd_addr, input ofm_rd_data, gold_rd_data);
    modport slave  (input rd_en, rd_addr, output ofm_rd_data, gold_rd_data);
endinterface

// File: rtl/ofm_checker.sv
// ofm_checker -- walks the whole OFM (TOTAL words) once per start, reading the
// RTL OFM and the golden OFM in lockstep and comparing each word pair against a
// signed absolute tolerance. Reports pass/fail, a saturating mismatch count and
// the address of the first mismatch.
// Ports:
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   start          : begin a pass (sampled only in IDLE)
//   stop_on_first  : abort at the first mismatch (latched at start)
//   mem            : read bus to OFM/golden memories (master side)
//   busy           : pass in progress (start accepted .. DONE)
//   done           : one-cycle completion pulse
//   pass           : result of the last completed pass
//   err_count      : mismatch count, saturates at all-ones
//   first_err_addr : address of the first mismatch of the last pass
module ofm_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int OFM_SIZE   = 32,
    parameter int NO_FILTER  = 16,
    parameter int TOLERANCE  = 0,
    localparam int TOTAL     = OFM_SIZE * OFM_SIZE * NO_FILTER,
    localparam int AW        = $clog2(TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop_on_first,
    ofm_checker_if.master        mem,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [AW:0]          err_count,
    output logic [AW-1:0]        first_err_addr
);
    localparam int             DW1  = DATA_WIDTH + 1;
    localparam logic [AW-1:0]  LAST = AW'(TOTAL - 1);
    localparam logic [DW1-1:0] TOL  = DW1'(TOLERANCE);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            stop_q, stop_d;
    logic            cmp_vld_q, cmp_vld_d;   // memory data this cycle belongs to a live read
    logic [AW-1:0]   cmp_addr_q, cmp_addr_d; // address that data came from
    logic [AW:0]     err_q, err_d;
    logic [AW-1:0]   ferr_q, ferr_d;
    logic            pass_q, pass_d;

    // Sign-extend by one bit before subtracting so full-range operands
    // (e.g. 32767 - (-32768)) cannot wrap.
    logic signed [DW1-1:0] diff;
    logic        [DW1-1:0] abs_diff;
    logic                  mismatch;

    assign diff     = $signed({mem.ofm_rd_data[DATA_WIDTH-1], mem.ofm_rd_data})
                    - $signed({mem.gold_rd_data[DATA_WIDTH-1], mem.gold_rd_data});
    assign abs_diff = diff[DW1-1] ? DW1'(-diff) : DW1'(diff);
    assign mismatch = cmp_vld_q && (abs_diff > TOL);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stop_d     = stop_q;
        cmp_vld_d  = 1'b0;
        cmp_addr_d = cmp_addr_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
        pass_d     = pass_q;

        // Compare stage: runs one cycle behind issue, so it is live during
        // READ and for the single DRAIN cycle.
        if (mismatch) begin
            if (err_q != {(AW+1){1'b1}}) err_d = err_q + 1'b1;
            if (err_q == '0)             ferr_d = cmp_addr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    stop_d  = stop_on_first;
                    err_d   = '0;
                    ferr_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_READ: begin
                if (stop_q && mismatch) begin
                    // Abort: the read issued this cycle is left unmarked, so its
                    // data is never compared.
                    state_d = S_DRAIN;
                end else begin
                    cmp_vld_d  = 1'b1;
                    cmp_addr_d = addr_q;
                    if (addr_q == LAST) state_d = S_DRAIN;
                    else                addr_d  = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                // err_d already includes the final in-flight compare.
                pass_d  = (err_d == '0);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            stop_q     <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
            err_q      <= '0;
            ferr_q     <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stop_q     <= stop_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_addr_q <= cmp_addr_d;
            err_q      <= err_d;
            ferr_q     <= ferr_d;
            pass_q     <= pass_d;
        end
    end

    assign mem.rd_en      = (state_q == S_READ);
    assign mem.rd_addr    = addr_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_ofm_checker.sv
// tb_ofm_checker -- directed bench for ofm_checker with a 2x2x2 OFM (8 words).
// dut0 runs with TOLERANCE=0, dut1 with TOLERANCE=1. Each has its own pair of
// behavioural memories returning data one cycle after rd_en.
module tb_ofm_checker;
    localparam int DW  = 16;
    localparam int OS  = 2;
    localparam int NF  = 2;
    localparam int TOT = 8;
    localparam int AW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, sof = 1'b0;
    always #5 clk = ~clk;

    ofm_checker_if #(.DATA_WIDTH(DW), .AW(AW)) m0 ();
    ofm_checker_if #(.DATA_WIDTH(DW), .AW(AW)) m1 ();

    logic          busy0, done0, pass0, busy1, done1, pass1;
    logic [AW:0]   ec0, ec1;
    logic [AW-1:0] fa0, fa1;

    ofm_checker #(.DATA_WIDTH(DW), .OFM_SIZE(OS), .NO_FILTER(NF), .TOLERANCE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop_on_first(sof), .mem(m0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .first_err_addr(fa0));

    ofm_checker #(.DATA_WIDTH(DW), .OFM_SIZE(OS), .NO_FILTER(NF), .TOLERANCE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop_on_first(sof), .mem(m1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .first_err_addr(fa1));

    logic signed [DW-1:0] ofm0 [TOT];
    logic signed [DW-1:0] gold0[TOT];
    logic signed [DW-1:0] ofm1 [TOT];
    logic signed [DW-1:0] gold1[TOT];

    always_ff @(posedge clk) begin
        if (m0.rd_en) begin
            m0.ofm_rd_data  <= ofm0[m0.rd_addr];
            m0.gold_rd_data <= gold0[m0.rd_addr];
        end
        if (m1.rd_en) begin
            m1.ofm_rd_data  <= ofm1[m1.rd_addr];
            m1.gold_rd_data <= gold1[m1.rd_addr];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic mem_init();
        for (int i = 0; i < TOT; i++) begin
            gold0[i] = 16'(i * 3 - 5);
            ofm0[i]  = gold0[i];
            gold1[i] = 16'(100 - i * 7);
            ofm1[i]  = gold1[i];
        end
    endtask

    // Pulse (or hold) start, then watch negedges: n=1 is the first negedge
    // after the start-sampling edge. Returns the negedge on which done is
    // seen (-1 on timeout) and a log of the reads issued.
    task automatic run(input int sel, input logic hold, output int dcyc, output int nrd,
                       output int fst, output int lst, output int seq_bad);
        logic          en, dn;
        logic [AW-1:0] ad;
        @(negedge clk);
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        dcyc = -1; nrd = 0; fst = -1; lst = -1; seq_bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1 && !hold) begin start0 = 1'b0; start1 = 1'b0; end
            en = (sel == 1) ? m1.rd_en   : m0.rd_en;
            ad = (sel == 1) ? m1.rd_addr : m0.rd_addr;
            dn = (sel == 1) ? done1      : done0;
            if (en) begin
                if (int'(ad) != nrd) seq_bad++;
                if (fst < 0) fst = n;
                lst = n;
                nrd++;
            end
            if (dn) begin
                dcyc = n;
                break;
            end
        end
    endtask

    int dcyc, nrd, fst, lst, sbad, dseen, n2;

    initial begin
        mem_init();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst rd_en",   m0.rd_en, 0);
        chk("rst rd_addr", m0.rd_addr, 0);
        chk("rst busy",    busy0, 0);
        chk("rst done",    done0, 0);
        chk("rst pass",    pass0, 0);
        chk("rst err",     ec0, 0);
        chk("rst ferr",    fa0, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle busy", busy0, 0);

        // Identical memories, full pass
        sof = 1'b0;
        run(0, 1'b0, dcyc, nrd, fst, lst, sbad);
        chk("t1 done cyc", dcyc, 10);
        chk("t1 nrd",      nrd, 8);
        chk("t1 first rd", fst, 1);
        chk("t1 last rd",  lst, 8);
        chk("t1 addr seq", sbad, 0);
        chk("t1 pass",     pass0, 1);
        chk("t1 err",      ec0, 0);
        repeat (3) @(negedge clk);
        chk("t1 hold pass", pass0, 1);
        chk("t1 hold addr", m0.rd_addr, 7);
        chk("t1 idle busy", busy0, 0);

        // Reset in the middle of a pass
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        @(negedge clk); start0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m0.rd_en && m0.rd_addr == 3'd4) break;
            @(negedge clk);
        end
        chk("t5 at addr4", m0.rd_addr, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 rd_en",   m0.rd_en, 0);
        chk("t5 rd_addr", m0.rd_addr, 0);
        chk("t5 busy",    busy0, 0);
        chk("t5 done",    done0, 0);
        chk("t5 pass",    pass0, 0);
        chk("t5 err",     ec0, 0);
        chk("t5 ferr",    fa0, 0);
        rst = 1'b0;
        dseen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done0 || busy0) dseen++;
        end
        chk("t5 no done", dseen, 0);
        run(0, 1'b0, dcyc, nrd, fst, lst, sbad);
        chk("t5 done cyc", dcyc, 10);
        chk("t5 pass",     pass0, 1);

        // Single mismatch, tolerance 0
        gold0[3] = 16'sd5; ofm0[3] = 16'sd6;
        run(0, 1'b0, dcyc, nrd, fst, lst, sbad);
        chk("t2 done cyc", dcyc, 10);
        chk("t2 pass",     pass0, 0);
        chk("t2 err",      ec0, 1);
        chk("t2 ferr",     fa0, 3);

        // Stop on first mismatch
        mem_init();
        ofm0[1] = gold0[1] + 16'sd7;
        ofm0[5] = gold0[5] - 16'sd2;
        sof = 1'b1;
        run(0, 1'b0, dcyc, nrd, fst, lst, sbad);
        sof = 1'b0;
        chk("t4 done cyc", dcyc, 5);
        chk("t4 nrd",      nrd, 3);
        chk("t4 last addr", m0.rd_addr, 2);
        chk("t4 err",      ec0, 1);
        chk("t4 ferr",     fa0, 1);
        chk("t4 pass",     pass0, 0);

        // Tolerance 1 with a full-range difference
        gold1[2] = -16'sd32768; ofm1[2] = 16'sd32767;
        gold1[6] = 16'sd4;      ofm1[6] = 16'sd5;
        run(1, 1'b0, dcyc, nrd, fst, lst, sbad);
        chk("t3 done cyc", dcyc, 10);
        chk("t3 err",      ec1, 1);
        chk("t3 ferr",     fa1, 2);
        chk("t3 pass",     pass1, 0);

        // Start held high: one pass, then a restart after one IDLE cycle
        mem_init();
        run(0, 1'b1, dcyc, nrd, fst, lst, sbad);
        chk("t6 done cyc", dcyc, 10);
        chk("t6 nrd",      nrd, 8);
        @(negedge clk);
        chk("t6 idle busy", busy0, 0);
        @(negedge clk);
        chk("t6 restart busy", busy0, 1);
        chk("t6 restart rd_en", m0.rd_en, 1);
        chk("t6 restart addr",  m0.rd_addr, 0);
        start0 = 1'b0;
        n2 = -1;
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            if (done0) begin n2 = n; break; end
        end
        chk("t6 second done", n2, 10);
        chk("t6 second pass", pass0, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
